// File: rtl/execute_pipe_if.sv
// Bundle of signals between the E stage, the pipeline control and the M stage.
// The slave side is the execute block; the master side drives E-stage operands and control.
interface execute_pipe_if #(
   parameter int WIDTH = 64
);
   logic                    E_valid;
   logic [3:0]              E_icode;
   logic [3:0]              E_ifun;
   logic signed [WIDTH-1:0] E_valA;
   logic signed [WIDTH-1:0] E_valB;
   logic signed [WIDTH-1:0] E_valC;
   logic [3:0]              E_dstE;
   logic [3:0]              E_dstM;
   logic                    set_cc_en;
   logic                    M_stall;
   logic                    M_bubble;

   logic signed [WIDTH-1:0] e_valE;
   logic                    e_cnd;
   logic [3:0]              e_dstE;
   logic [2:0]              cc;
   logic                    M_valid;
   logic [3:0]              M_icode;
   logic [3:0]              M_ifun;
   logic                    M_cnd;
   logic signed [WIDTH-1:0] M_valE;
   logic signed [WIDTH-1:0] M_valA;
   logic [3:0]              M_dstE;
   logic [3:0]              M_dstM;

   modport master (
      output E_valid, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
             set_cc_en, M_stall, M_bubble,
      input  e_valE, e_cnd, e_dstE, cc,
             M_valid, M_icode, M_ifun, M_cnd, M_valE, M_valA, M_dstE, M_dstM
   );

   modport slave (
      input  E_valid, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
             set_cc_en, M_stall, M_bubble,
      output e_valE, e_cnd, e_dstE, cc,
             M_valid, M_icode, M_ifun, M_cnd, M_valE, M_valA, M_dstE, M_dstM
   );
endinterface

// File: rtl/execute_pipe.sv
// Y86-64 execute stage: ALU, condition codes, branch/cmov condition and the E->M register.
// e_valE/e_cnd/e_dstE are combinational so decode can forward from them in the same cycle.
module execute_pipe #(
   parameter int WIDTH = 64,
   parameter int STEP  = WIDTH / 8
) (
   input  logic          clk,
   input  logic          rst,
   execute_pipe_if.slave bus
);

   typedef enum logic [2:0] {ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR} alu_op_e;

   localparam logic signed [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
   localparam logic [3:0]              REG_NONE = 4'hF;
   localparam logic [3:0]              I_NOP    = 4'h1;
   localparam logic [3:0]              I_CMOV   = 4'h2;
   localparam logic [3:0]              I_OPQ    = 4'h6;
   localparam logic [3:0]              I_JXX    = 4'h7;

   // Condition evaluation against a {ZF,SF,OF} vector.
   function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] flags);
      logic zf, sf, of;
      zf = flags[2];
      sf = flags[1];
      of = flags[0];
      case (ifun)
         4'd0:    cond_eval = 1'b1;
         4'd1:    cond_eval = (sf ^ of) | zf;
         4'd2:    cond_eval = sf ^ of;
         4'd3:    cond_eval = zf;
         4'd4:    cond_eval = !zf;
         4'd5:    cond_eval = !(sf ^ of);
         4'd6:    cond_eval = !(sf ^ of) && !zf;
         default: cond_eval = 1'b0;
      endcase
   endfunction

   alu_op_e                 w_op;
   logic signed [WIDTH-1:0] w_alu_a;
   logic signed [WIDTH-1:0] w_alu_b;
   logic signed [WIDTH-1:0] w_result;
   logic                    w_of;
   logic                    w_zf;
   logic                    w_sf;
   logic                    w_cc_load;
   logic                    w_cnd;
   logic [3:0]              w_dst_e;
   logic                    w_take;

   logic [2:0]              r_cc;
   logic                    r_valid_p1;
   logic [3:0]              r_icode_p1;
   logic [3:0]              r_ifun_p1;
   logic                    r_cnd_p1;
   logic signed [WIDTH-1:0] r_valE_p1;
   logic signed [WIDTH-1:0] r_valA_p1;
   logic [3:0]              r_dstE_p1;
   logic [3:0]              r_dstM_p1;

   // ---- E stage (p0): operand selection ----
   always_comb begin
      w_alu_a = '0;
      w_alu_b = '0;
      w_op    = ALU_NONE;
      case (bus.E_icode)
         4'h2: begin
            w_alu_a = bus.E_valA;
            w_op    = ALU_ADD;
         end
         4'h3: begin
            w_alu_a = bus.E_valC;
            w_op    = ALU_ADD;
         end
         4'h4, 4'h5: begin
            w_alu_a = bus.E_valC;
            w_alu_b = bus.E_valB;
            w_op    = ALU_ADD;
         end
         4'h6: begin
            w_alu_a = bus.E_valA;
            w_alu_b = bus.E_valB;
            case (bus.E_ifun)
               4'd0:    w_op = ALU_ADD;
               4'd1:    w_op = ALU_SUB;
               4'd2:    w_op = ALU_AND;
               4'd3:    w_op = ALU_XOR;
               default: w_op = ALU_NONE;
            endcase
         end
         4'h8, 4'hA: begin
            w_alu_a = -STEP_W;
            w_alu_b = bus.E_valB;
            w_op    = ALU_ADD;
         end
         4'h9, 4'hB: begin
            w_alu_a = STEP_W;
            w_alu_b = bus.E_valB;
            w_op    = ALU_ADD;
         end
         default: ;
      endcase
   end

   // Subtraction computes B-A, so its overflow is judged against B's sign.
   always_comb begin
      w_result = '0;
      w_of     = 1'b0;
      case (w_op)
         ALU_ADD: begin
            w_result = w_alu_b + w_alu_a;
            w_of     = (w_alu_a[WIDTH-1] == w_alu_b[WIDTH-1]) &&
                       (w_result[WIDTH-1] != w_alu_a[WIDTH-1]);
         end
         ALU_SUB: begin
            w_result = w_alu_b - w_alu_a;
            w_of     = (w_alu_a[WIDTH-1] != w_alu_b[WIDTH-1]) &&
                       (w_result[WIDTH-1] != w_alu_b[WIDTH-1]);
         end
         ALU_AND: w_result = w_alu_b & w_alu_a;
         ALU_XOR: w_result = w_alu_b ^ w_alu_a;
         default: ;
      endcase
   end

   assign w_zf      = (w_result == '0);
   assign w_sf      = w_result[WIDTH-1];
   assign w_cc_load = bus.E_valid && (bus.E_icode == I_OPQ) && (bus.E_ifun <= 4'd3) &&
                      bus.set_cc_en && !bus.M_stall;
   assign w_cnd     = ((bus.E_icode == I_CMOV) || (bus.E_icode == I_JXX)) ?
                      cond_eval(bus.E_ifun, r_cc) : 1'b0;
   assign w_dst_e   = ((bus.E_icode == I_CMOV) && !w_cnd) ? REG_NONE : bus.E_dstE;
   assign w_take    = bus.E_valid && !bus.M_bubble;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cc <= 3'b100;
      end else if (w_cc_load) begin
         r_cc <= {w_zf, w_sf, w_of};
      end
   end

   // ---- E->M register (p1) ----
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid_p1 <= 1'b0;
         r_icode_p1 <= I_NOP;
         r_ifun_p1  <= 4'h0;
         r_cnd_p1   <= 1'b0;
         r_valE_p1  <= '0;
         r_valA_p1  <= '0;
         r_dstE_p1  <= REG_NONE;
         r_dstM_p1  <= REG_NONE;
      end else if (!bus.M_stall) begin
         if (w_take) begin
            r_valid_p1 <= 1'b1;
            r_icode_p1 <= bus.E_icode;
            r_ifun_p1  <= bus.E_ifun;
            r_cnd_p1   <= w_cnd;
            r_valE_p1  <= w_result;
            r_valA_p1  <= bus.E_valA;
            r_dstE_p1  <= w_dst_e;
            r_dstM_p1  <= bus.E_dstM;
         end else begin
            r_valid_p1 <= 1'b0;
            r_icode_p1 <= I_NOP;
            r_ifun_p1  <= 4'h0;
            r_cnd_p1   <= 1'b0;
            r_valE_p1  <= '0;
            r_valA_p1  <= '0;
            r_dstE_p1  <= REG_NONE;
            r_dstM_p1  <= REG_NONE;
         end
      end
   end

   assign bus.e_valE  = w_result;
   assign bus.e_cnd   = w_cnd;
   assign bus.e_dstE  = w_dst_e;
   assign bus.cc      = r_cc;
   assign bus.M_valid = r_valid_p1;
   assign bus.M_icode = r_icode_p1;
   assign bus.M_ifun  = r_ifun_p1;
   assign bus.M_cnd   = r_cnd_p1;
   assign bus.M_valE  = r_valE_p1;
   assign bus.M_valA  = r_valA_p1;
   assign bus.M_dstE  = r_dstE_p1;
   assign bus.M_dstM  = r_dstM_p1;

endmodule

// File: tb/tb_execute_pipe.sv
// Bench for execute_pipe: directed cases plus randomized traffic against a behavioural model.
module tb_execute_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   execute_pipe_if #(.WIDTH(64)) bus ();
   execute_pipe_if #(.WIDTH(32)) bus32 ();

   execute_pipe #(.WIDTH(64)) dut   (.clk(clk), .rst(rst), .bus(bus.slave));
   execute_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));

   typedef struct packed {
      logic        valid;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic        cnd;
      logic [63:0] valE;
      logic [63:0] valA;
      logic [3:0]  dstE;
      logic [3:0]  dstM;
   } mreg_t;

   localparam mreg_t NOP = '{valid: 1'b0, icode: 4'h1, ifun: 4'h0, cnd: 1'b0,
                             valE: 64'h0, valA: 64'h0, dstE: 4'hF, dstM: 4'hF};

   int    n_cmp = 0;
   int    n_mis = 0;
   logic [2:0] m_cc;
   mreg_t      m_reg;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference behaviour straight from the ISA rules, using exact-width overflow detection.
   task automatic model_comb(output logic [63:0] v, output logic c, output logic [3:0] d,
                             output logic [2:0] f, output logic wr);
      logic [63:0] a, b;
      logic [64:0] wide;
      logic        of, ok, cz, cs, co;
      a = bus.E_valA; b = bus.E_valB; of = 1'b0; ok = 1'b0; v = '0;
      case (bus.E_icode)
         4'h2: v = a;
         4'h3: v = bus.E_valC;
         4'h4, 4'h5: v = bus.E_valC + b;
         4'h6: begin
            ok = (bus.E_ifun <= 4'd3);
            case (bus.E_ifun)
               4'd0: begin wide = {b[63], b} + {a[63], a}; v = wide[63:0]; of = wide[64] != wide[63]; end
               4'd1: begin wide = {b[63], b} - {a[63], a}; v = wide[63:0]; of = wide[64] != wide[63]; end
               4'd2: v = b & a;
               4'd3: v = b ^ a;
               default: v = '0;
            endcase
         end
         4'h8, 4'hA: v = b - 64'd8;
         4'h9, 4'hB: v = b + 64'd8;
         default: v = '0;
      endcase
      f  = {(v == 64'h0), v[63], of};
      cz = m_cc[2]; cs = m_cc[1]; co = m_cc[0];
      c  = 1'b0;
      if (bus.E_icode == 4'h2 || bus.E_icode == 4'h7) begin
         case (bus.E_ifun)
            4'd0: c = 1'b1;
            4'd1: c = (cs ^ co) | cz;
            4'd2: c = cs ^ co;
            4'd3: c = cz;
            4'd4: c = !cz;
            4'd5: c = !(cs ^ co);
            4'd6: c = !(cs ^ co) && !cz;
            default: c = 1'b0;
         endcase
      end
      d  = (bus.E_icode == 4'h2 && !c) ? 4'hF : bus.E_dstE;
      wr = bus.E_valid && ok && bus.set_cc_en && !bus.M_stall;
   endtask

   // One clock: check combinational outputs, advance the model, check registered outputs.
   task automatic step();
      logic [63:0] v;
      logic        c, wr;
      logic [3:0]  d;
      logic [2:0]  f;
      #1;
      model_comb(v, c, d, f, wr);
      chk("e_valE", bus.e_valE, v);
      chk("e_cnd", bus.e_cnd, c);
      chk("e_dstE", bus.e_dstE, d);
      @(posedge clk);
      #1;
      if (rst) begin
         m_cc  = 3'b100;
         m_reg = NOP;
      end else begin
         if (wr) m_cc = f;
         if (!bus.M_stall) begin
            if (bus.E_valid && !bus.M_bubble) begin
               m_reg.valid = 1'b1;        m_reg.icode = bus.E_icode;
               m_reg.ifun  = bus.E_ifun;  m_reg.cnd   = c;
               m_reg.valE  = v;           m_reg.valA  = bus.E_valA;
               m_reg.dstE  = d;           m_reg.dstM  = bus.E_dstM;
            end else begin
               m_reg = NOP;
            end
         end
      end
      chk("cc", bus.cc, m_cc);
      chk("M_valid", bus.M_valid, m_reg.valid);
      chk("M_icode", bus.M_icode, m_reg.icode);
      chk("M_ifun", bus.M_ifun, m_reg.ifun);
      chk("M_cnd", bus.M_cnd, m_reg.cnd);
      chk("M_valE", bus.M_valE, m_reg.valE);
      chk("M_valA", bus.M_valA, m_reg.valA);
      chk("M_dstE", bus.M_dstE, m_reg.dstE);
      chk("M_dstM", bus.M_dstM, m_reg.dstM);
   endtask

   task automatic set_e(input logic vld, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                        input logic [3:0] de, input logic [3:0] dm);
      bus.E_valid = vld; bus.E_icode = ic; bus.E_ifun = fn;
      bus.E_valA = va; bus.E_valB = vb; bus.E_valC = vc;
      bus.E_dstE = de; bus.E_dstM = dm;
   endtask

   task automatic set_ctl(input logic en, input logic stall, input logic bub);
      bus.set_cc_en = en; bus.M_stall = stall; bus.M_bubble = bub;
   endtask

   function automatic logic [63:0] rnd64();
      case ($urandom_range(0, 6))
         0:       rnd64 = 64'h0;
         1:       rnd64 = 64'h8000_0000_0000_0000;
         2:       rnd64 = 64'h7FFF_FFFF_FFFF_FFFF;
         3:       rnd64 = 64'($urandom_range(0, 16));
         4:       rnd64 = '1;
         default: rnd64 = {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      m_cc  = 3'b100;
      m_reg = NOP;
      bus32.E_valid = 1'b0; bus32.E_icode = 4'h1; bus32.E_ifun = 4'h0;
      bus32.E_valA = '0; bus32.E_valB = '0; bus32.E_valC = '0;
      bus32.E_dstE = 4'hF; bus32.E_dstM = 4'hF;
      bus32.set_cc_en = 1'b1; bus32.M_stall = 1'b0; bus32.M_bubble = 1'b0;

      rst = 1'b1;
      set_ctl(1'b1, 1'b0, 1'b0);
      set_e(1'b0, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
      step();
      step();
      chk("rst_cc", bus.cc, 3'b100);
      chk("rst_valid", bus.M_valid, 1'b0);
      rst = 1'b0;

      set_e(1'b1, 4'h6, 4'h0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 4'h2, 4'hF);
      step();
      chk("ovf_add_cc", bus.cc, 3'b101);
      chk("ovf_add_valE", bus.M_valE, 64'h0);

      set_e(1'b1, 4'h6, 4'h1, 64'd5, 64'd3, 64'h0, 4'h2, 4'hF);
      step();
      chk("sub_valE", bus.M_valE, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("sub_cc", bus.cc, 3'b010);
      set_e(1'b1, 4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
      #1 chk("jl_cnd", bus.e_cnd, 1'b1);
      step();
      set_e(1'b1, 4'h7, 4'h3, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
      #1 chk("je_cnd", bus.e_cnd, 1'b0);
      step();

      set_e(1'b1, 4'h2, 4'h3, 64'h2A, 64'h0, 64'h0, 4'h3, 4'hF);
      #1 chk("cmov_nt_dst", bus.e_dstE, 4'hF);
      step();
      chk("cmov_nt_M_dst", bus.M_dstE, 4'hF);
      chk("cmov_valE", bus.M_valE, 64'h2A);
      set_e(1'b1, 4'h6, 4'h3, 64'd7, 64'd7, 64'h0, 4'h4, 4'hF);
      step();
      set_e(1'b1, 4'h2, 4'h3, 64'h2A, 64'h0, 64'h0, 4'h3, 4'hF);
      step();
      chk("cmov_t_M_dst", bus.M_dstE, 4'h3);

      set_e(1'b1, 4'hA, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4, 4'hF);
      bus32.E_valid = 1'b1; bus32.E_icode = 4'hA; bus32.E_valB = 32'h100;
      step();
      chk("push_valE", bus.M_valE, 64'hF8);
      chk("push32_valE", 64'(bus32.M_valE), 64'hFC);
      set_e(1'b1, 4'hB, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4, 4'h5);
      bus32.E_icode = 4'hB;
      step();
      chk("pop_valE", bus.M_valE, 64'h108);
      chk("pop32_valE", 64'(bus32.M_valE), 64'h104);
      bus32.E_valid = 1'b0;

      set_e(1'b1, 4'h6, 4'h1, 64'd5, 64'd3, 64'h0, 4'h2, 4'hF);
      step();
      set_ctl(1'b0, 1'b0, 1'b0);
      set_e(1'b1, 4'h6, 4'h0, 64'd1, '1, 64'h0, 4'h2, 4'hF);
      step();
      chk("cc_en_off_cc", bus.cc, 3'b010);
      set_ctl(1'b1, 1'b1, 1'b0);
      step();
      chk("stall_cc", bus.cc, 3'b010);

      set_ctl(1'b1, 1'b0, 1'b1);
      set_e(1'b1, 4'h3, 4'h0, 64'h0, 64'h0, 64'h55, 4'h6, 4'hF);
      step();
      chk("bubble_valid", bus.M_valid, 1'b0);
      chk("bubble_icode", bus.M_icode, 4'h1);
      set_ctl(1'b1, 1'b0, 1'b0);
      step();
      set_ctl(1'b1, 1'b1, 1'b1);
      step();
      chk("stall_bubble_valE", bus.M_valE, 64'h55);
      set_e(1'b1, 4'h6, 4'h1, 64'd5, 64'd3, 64'h0, 4'h2, 4'hF);
      rst = 1'b1;
      step();
      chk("rst_stall_cc", bus.cc, 3'b100);
      chk("rst_stall_dstE", bus.M_dstE, 4'hF);
      rst = 1'b0;

      for (int i = 0; i < 600; i++) begin
         set_e($urandom_range(0, 9) != 0, 4'($urandom_range(0, 12)), 4'($urandom_range(0, 7)),
               rnd64(), rnd64(), rnd64(), 4'($urandom), 4'($urandom));
         set_ctl($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
         rst = ($urandom_range(0, 49) == 0);
         step();
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/execute_pipe.md
# execute_pipe

Parametrised pipelined execute stage for the Y86-64 processor. It evaluates the ALU result (valE) and branch/move condition (cnd) for the instruction in the E stage, and holds the condition codes in a register. It latches results into the E→M pipeline register with stall/bubble control. It sits between the decode pipeline register and the memory stage, and provides combinational forwarding outputs back to decode.

## Interface
- WIDTH, 64: datapath width in bits; must be a multiple of 8, ≥16.
- STEP, WIDTH/8: stack pointer adjustment for push/pop/call/ret.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- E_valid  in  1  E stage holds a real instruction.
- E_icode, E_ifun  in  4 each  instruction code and function.
- E_valA, E_valB, E_valC  in  WIDTH each  signed operands.
- E_dstE, E_dstM  in  4 each  destination register IDs; 4'hF means none.
- set_cc_en  in  1  pipeline control permits a CC update; deasserted when M/W holds an exception.
- M_stall  in  1  hold the M register.
- M_bubble  in  1  load a nop into the M register.
- e_valE  out  WIDTH  combinational ALU result, used for forwarding.
- e_cnd  out  1  combinational condition result.
- e_dstE  out  4  E_dstE, forced to 4'hF for an untaken cmovXX.
- cc  out  3  registered {ZF,SF,OF}.
- M_valid, M_icode, M_ifun, M_cnd, M_valE, M_valA, M_dstE, M_dstM  out  registered copies for the M stage.

## Operation
- ALU input A, ALU input B and operation, by E_icode:
  - 2 (rrmov/cmov): A=valA, B=0, add.
  - 3 (irmovq): A=valC, B=0, add.
  - 4 and 5 (rm/mrmovq): A=valC, B=valB, add.
  - 6 (OPq): A=valA, B=valB, operation selected by E_ifun.
  - 8 and A (call/push): A=−STEP, B=valB, add.
  - 9 and B (ret/pop): A=+STEP, B=valB, add.
  - all other codes: e_valE=0.
- OPq functions: ifun 0 gives B+A; 1 gives B−A; 2 gives B&A; 3 gives B^A; ifun >3 gives e_valE=0 and no CC update.
- All arithmetic is two's complement, modulo 2^WIDTH.
- Computed flags:
  - ZF = (result==0).
  - SF = result[WIDTH-1].
  - OF for add = (A,B same sign) && (result sign ≠ A sign).
  - OF for sub = (A,B differing sign) && (result sign ≠ B sign).
  - OF for and/xor = 0.
- CC register loads the computed flags when E_valid && E_icode==6 && E_ifun≤3 && set_cc_en && !M_stall. Otherwise CC holds.
- e_cnd is valid only for icode 2 and 7 and uses the current registered cc, not the flags being computed. With ifun: 0 always; 1 le=(SF^OF)|ZF; 2 l=SF^OF; 3 e=ZF; 4 ne=!ZF; 5 ge=!(SF^OF); 6 g=!(SF^OF)&!ZF; ifun >6 gives 0. For other icodes e_cnd=0.
- e_dstE = 4'hF when E_icode==2 && !e_cnd; otherwise E_dstE.
- M register update priority: rst, then M_stall (hold), then M_bubble (nop), then load.
- Load: M_valid=E_valid and the M_* fields take the E-stage values, with M_dstE=e_dstE and M_cnd=e_cnd.
- If E_valid=0, the register loads a nop exactly as a bubble does.
- Nop / reset value: M_valid=0, M_icode=4'h1, M_ifun=0, M_cnd=0, M_valE=0, M_valA=0, M_dstE=M_dstM=4'hF.
- Reset: cc=3'b100 (ZF=1, SF=0, OF=0).

## Timing
- Latency: one cycle from E inputs to M outputs. e_valE, e_cnd and e_dstE are combinational in the same cycle.
- An OPq at edge n updates cc at edge n. A jXX or cmov in E during the following cycle sees the new cc.
- Simultaneous M_stall and M_bubble: stall wins, so M and cc hold.
- M_bubble does not block a CC update; only set_cc_en and M_stall do.
- rst asserted mid-stream: the next edge forces the reset values regardless of stall/bubble. Outputs are driven by the reset values from that edge until the first edge with rst low.

## Test plan
- Reset, then E_icode=6, ifun=0, valA=valB=0x8000000000000000 → e_valE=0; after the edge cc=3'b101 (ZF=1, OF=1), M_valE=0.
- OPq sub (ifun=1) with valA=5, valB=3 → e_valE=−2; cc=3'b010. The next cycle, jXX with ifun=2 (l) gives e_cnd=1, and jXX with ifun=3 (e) gives e_cnd=0.
- cmovXX ifun=3 with cc ZF=0, valA=0x2A, E_dstE=3 → e_valE=0x2A, e_dstE=4'hF, M_dstE=4'hF after the edge. With ZF=1 → M_dstE=3.
- pushq with valB=0x100 → M_valE=0xF8. popq with valB=0x100 → M_valE=0x108. With WIDTH=32 the same cases give 0xFC and 0x104.
- OPq add with valA=1, valB=−1 and set_cc_en=0 → e_valE=0, cc unchanged. Repeating the add with set_cc_en=1 and M_stall=1 → M_* and cc both hold.
- M_bubble=1 with a valid irmovq in E → M_valid=0, M_icode=1, M_dstE=4'hF. Setting M_stall=M_bubble=1 → hold. Asserting rst during a stall → nop values and cc=3'b100 at the next edge.
